instr_register_mc: RTL and testbench
====================================

# instr_register_mc

Parametrised, multi-cycle successor of the instruction register. It accepts an opcode and two signed operands through a ready/valid-style write port and computes the result. Single-cycle opcodes use a combinational ALU; DIV/MOD use an iterative divider. It stores opcode, operands, result and a divide-by-zero flag in a DEPTH-entry array, and returns entries through a registered read port. It sits between the stimulus/decoder front end and any result consumer in the lab DUT.

## Interface
- OP_WIDTH, 32: signed operand width (≥4)
- DEPTH, 32: number of entries (power of two, ≥2); AW = $clog2(DEPTH)
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_en  in  1  write request
- wr_ready  out  1  write accepted when load_en && wr_ready at a rising edge
- opcode  in  opcode_t  operation
- operand_a, operand_b  in  OP_WIDTH  signed operands
- write_pointer  in  AW  destination entry
- read_pointer  in  AW  entry to read
- instruction_word  out  entry_t  registered read data
- busy  out  1  divider running

## Operation
- Entry fields: opc, op_a, op_b, result (signed, 2*OP_WIDTH), dbz (1).
- Results are sign-extended to 2*OP_WIDTH:
  - ZERO = 0; PASSA = a; PASSB = b; ADD = a+b; SUB = a−b; MULT = a*b (full product).
  - DIV = a/b, truncating toward zero.
  - MOD = a%b, remainder takes the sign of a.
  - Unlisted codes = 0.
- Divide by zero: DIV result all-ones (−1), MOD result = a, dbz=1. dbz=0 for every other case.
- Most-negative / −1 yields +2^(OP_WIDTH−1) with no overflow, because the result is wide.
- Single-cycle ops (all except DIV/MOD): the entry is written at the accepting edge. wr_ready stays 1.
- DIV/MOD: opcode, operands and write_pointer are captured at the accepting edge. The FSM then runs:
  - IDLE→DIV at the accepting edge.
  - DIV performs one restoring step per edge, OP_WIDTH steps in total, on magnitudes with the sign fixed at the end.
  - DIV→IDLE at the final edge, where the entry is written.
  - Divide by zero completes in the same OP_WIDTH cycles. No early exit.
- wr_ready = (state==IDLE); busy = (state==DIV). load_en while not ready is ignored, with no queuing.
- Read data: instruction_word <= array[read_pointer] every edge.
- Same-edge read and write to the same address returns the old contents (read-before-write).
- Reset clears all entries to opc=ZERO with all other fields 0, clears instruction_word, and forces IDLE.
  - Reset during DIV aborts the operation; no entry is written.

## Timing
- Single-cycle op accepted at edge E0: entry visible on instruction_word after edge E1 (read_pointer held).
- DIV/MOD accepted at E0: wr_ready/busy change after E0. The entry is written at E_OP_WIDTH, and wr_ready=1 from that edge.
- Back-to-back single-cycle writes: one per cycle.
- Reset values: wr_ready=0 while reset_n=0, then 1. busy=0. instruction_word all zero.

## Configuration
- INSTR_REG_DIV_EN defined: iterative divider instantiated; DIV/MOD behave as above.
- Not defined: no divider and no DIV state. DIV/MOD complete in one cycle with result 0 and dbz=1. wr_ready stays 1 and busy stays 0.

## Structure
- instr_register_pkg holds:
  - opcode_t enum: ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD, 4-bit.
  - Default width and depth constants.
  - The entry field order. Width-dependent entry_t is declared in the module from OP_WIDTH.
- Sub-module instr_divider, parametrised by OP_WIDTH:
  - Inputs: start, a, b.
  - Outputs: done pulse, quot, rem, dbz.
  - Owns the step counter and the sign fix-up.

## Test plan
- Reset, then read all DEPTH entries → every entry opc=ZERO with all fields 0. wr_ready=1 one edge after reset_n rises.
- ADD a=5, b=−7 to entry 3, then read 3 → result −2, dbz=0, visible one edge after the write.
- With INSTR_REG_DIV_EN, DIV a=−17, b=5 to entry 4 → busy for 32 cycles; quot −3. MOD to entry 5 gives −2. A load_en during busy is not written.
- DIV a=9, b=0 → result −1, dbz=1. MOD a=9, b=0 → result 9, dbz=1.
- MULT a=−2^31, b=−2^31 → result 2^62. DIV a=−2^31, b=−1 → result 2^31.
- Assert reset_n=0 mid-DIV (cycle 10) → target entry stays zero, busy=0. Same-edge read/write of one entry returns the old value.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types and constants for the multi-cycle instruction register.
// Entry layout, MSB to LSB: opc, op_a, op_b, result, dbz.
package instr_register_pkg;

  localparam int OPC_W        = 4;
  localparam int DEF_OP_WIDTH = 32;
  localparam int DEF_DEPTH    = 32;

  typedef enum logic [OPC_W-1:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  function automatic int entry_w(input int w);
    return OPC_W + 4 * w + 1;
  endfunction

endpackage

// File: rtl/instr_divider.sv
// Iterative restoring divider: OP_WIDTH steps on magnitudes,
// signs applied to the final step's quotient and remainder.
module instr_divider #(
  parameter int OP_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic signed [OP_WIDTH-1:0]   a,
  input  logic signed [OP_WIDTH-1:0]   b,
  output logic                         done,
  output logic signed [2*OP_WIDTH-1:0] quot,
  output logic signed [2*OP_WIDTH-1:0] rem,
  output logic                         dbz
);

  localparam int W  = OP_WIDTH;
  localparam int CW = $clog2(W) + 1;

  logic                run;
  logic [CW-1:0]       cnt;
  logic [W-1:0]        q;
  logic [W-1:0]        d;
  logic [W-1:0]        r;
  logic                neg_q;
  logic                neg_r;
  logic                zero;
  logic signed [W-1:0] a_q;

  logic [W:0]          r_sh;
  logic [W:0]          diff;
  logic                ge;
  logic [W-1:0]        r_nx;
  logic [W-1:0]        q_nx;
  logic [2*W-1:0]      q_ext;
  logic [2*W-1:0]      r_ext;

  function automatic logic [W-1:0] mag(
    input logic signed [W-1:0] v
  );
    return v[W-1] ? -v : v;
  endfunction

  always_comb begin
    r_sh  = {r, q[W-1]};
    diff  = r_sh - {1'b0, d};
    ge    = ~diff[W];
    r_nx  = ge ? diff[W-1:0] : r_sh[W-1:0];
    q_nx  = {q[W-2:0], ge};
    q_ext = {{W{1'b0}}, q_nx};
    r_ext = {{W{1'b0}}, r_nx};
  end

  // Outputs reflect the step in flight, valid while done is high.
  assign done = run && (cnt == CW'(W - 1));
  assign dbz  = zero;

  always_comb begin
    quot = zero ? '1 : (neg_q ? -q_ext : q_ext);
    rem  = zero ? {{W{a_q[W-1]}}, a_q}
                : (neg_r ? -r_ext : r_ext);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run   <= 1'b0;
      cnt   <= '0;
      q     <= '0;
      d     <= '0;
      r     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      zero  <= 1'b0;
      a_q   <= '0;
    end else if (start) begin
      run   <= 1'b1;
      cnt   <= '0;
      q     <= mag(a);
      d     <= mag(b);
      r     <= '0;
      neg_q <= a[W-1] ^ b[W-1];
      neg_r <= a[W-1];
      zero  <= (b == '0);
      a_q   <= a;
    end else if (run) begin
      q   <= q_nx;
      r   <= r_nx;
      cnt <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_register_mc.sv
// Multi-cycle instruction register with ALU and registered read port.
// INSTR_REG_DIV_EN enables the iterative DIV/MOD path.
module instr_register_mc
  import instr_register_pkg::*;
#(
  parameter  int OP_WIDTH = DEF_OP_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  localparam int AW       = $clog2(DEPTH),
  localparam int EW       = entry_w(OP_WIDTH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load_en,
  output logic                       wr_ready,
  input  opcode_t                    opcode,
  input  logic signed [OP_WIDTH-1:0] operand_a,
  input  logic signed [OP_WIDTH-1:0] operand_b,
  input  logic [AW-1:0]              write_pointer,
  input  logic [AW-1:0]              read_pointer,
  output logic [EW-1:0]              instruction_word,
  output logic                       busy
);

  typedef struct packed {
    opcode_t                      opc;
    logic signed [OP_WIDTH-1:0]   op_a;
    logic signed [OP_WIDTH-1:0]   op_b;
    logic signed [2*OP_WIDTH-1:0] result;
    logic                         dbz;
  } entry_t;

  entry_t                       mem [DEPTH];
  entry_t                       wr_e;
  logic                         wr_en;
  logic [AW-1:0]                wr_addr;
  logic                         rdy_q;
  logic                         accept;
  logic signed [2*OP_WIDTH-1:0] sa;
  logic signed [2*OP_WIDTH-1:0] sb;
  logic signed [2*OP_WIDTH-1:0] alu_res;
  logic                         alu_dbz;

  assign accept = load_en && wr_ready;

  always_comb begin
    sa      = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
    sb      = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};
    alu_res = '0;
    alu_dbz = 1'b0;
    unique case (1'b1)
      (opcode == PASSA): alu_res = sa;
      (opcode == PASSB): alu_res = sb;
      (opcode == ADD):   alu_res = sa + sb;
      (opcode == SUB):   alu_res = sa - sb;
      (opcode == MULT):  alu_res = sa * sb;
      (opcode == DIV),
      (opcode == MOD):   alu_dbz = 1'b1;
      default: ;
    endcase
  end

  // Held low through reset and for the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

`ifdef INSTR_REG_DIV_EN
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DIV  = 1'b1;

  logic [0:0]                   state;
  logic                         is_div;
  logic                         dv_start;
  logic                         dv_done;
  logic                         dv_dbz;
  logic signed [2*OP_WIDTH-1:0] dv_quot;
  logic signed [2*OP_WIDTH-1:0] dv_rem;
  opcode_t                      cap_opc;
  logic signed [OP_WIDTH-1:0]   cap_a;
  logic signed [OP_WIDTH-1:0]   cap_b;
  logic [AW-1:0]                cap_wp;

  assign is_div   = (opcode == DIV) || (opcode == MOD);
  assign dv_start = accept && is_div;
  assign wr_ready = rdy_q && (state == S_IDLE);
  assign busy     = (state == S_DIV);

  instr_divider #(
    .OP_WIDTH(OP_WIDTH)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (dv_start),
    .a      (operand_a),
    .b      (operand_b),
    .done   (dv_done),
    .quot   (dv_quot),
    .rem    (dv_rem),
    .dbz    (dv_dbz)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      state <= S_IDLE;
    else if (dv_start) state <= S_DIV;
    else if (dv_done)  state <= S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_opc <= ZERO;
      cap_a   <= '0;
      cap_b   <= '0;
      cap_wp  <= '0;
    end else if (dv_start) begin
      cap_opc <= opcode;
      cap_a   <= operand_a;
      cap_b   <= operand_b;
      cap_wp  <= write_pointer;
    end
  end

  always_comb begin
    wr_en       = accept && !is_div;
    wr_addr     = write_pointer;
    wr_e.opc    = opcode;
    wr_e.op_a   = operand_a;
    wr_e.op_b   = operand_b;
    wr_e.result = alu_res;
    wr_e.dbz    = alu_dbz;
    if (dv_done) begin
      wr_en       = 1'b1;
      wr_addr     = cap_wp;
      wr_e.opc    = cap_opc;
      wr_e.op_a   = cap_a;
      wr_e.op_b   = cap_b;
      wr_e.result = (cap_opc == DIV) ? dv_quot : dv_rem;
      wr_e.dbz    = dv_dbz;
    end
  end
`else
  assign wr_ready = rdy_q;
  assign busy     = 1'b0;

  always_comb begin
    wr_en       = accept;
    wr_addr     = write_pointer;
    wr_e.opc    = opcode;
    wr_e.op_a   = operand_a;
    wr_e.op_b   = operand_b;
    wr_e.result = alu_res;
    wr_e.dbz    = alu_dbz;
  end
`endif

  // Non-blocking read gives old data on a same-address write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      instruction_word <= '0;
    end else begin
      instruction_word <= mem[read_pointer];
      if (wr_en) mem[wr_addr] <= wr_e;
    end
  end

endmodule

// File: tb/tb_instr_register_mc.sv
// Bench for instr_register_mc: arithmetic model plus directed checks.
// Expectations follow INSTR_REG_DIV_EN when it is defined.
module tb_instr_register_mc;
  import instr_register_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int EW    = 4 + 4 * W + 1;
`ifdef INSTR_REG_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] opc;
    int         a;
    int         b;
    longint     r;
    bit         z;
  } ent_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                load_en;
  logic                wr_ready;
  opcode_t             opcode;
  logic signed [W-1:0] operand_a;
  logic signed [W-1:0] operand_b;
  logic [AW-1:0]       write_pointer;
  logic [AW-1:0]       read_pointer;
  logic [EW-1:0]       instruction_word;
  logic                busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  ent_t          m [DEPTH];
  ent_t          cap;
  int            cap_wp;
  int            dleft;
  bit            rdy_m;
  logic [EW-1:0] exp_iw;

  instr_register_mc #(
    .OP_WIDTH(W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .load_en         (load_en),
    .wr_ready        (wr_ready),
    .opcode          (opcode),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .write_pointer   (write_pointer),
    .read_pointer    (read_pointer),
    .instruction_word(instruction_word),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] pack(input ent_t e);
    return {e.opc, e.a, e.b, e.r, e.z};
  endfunction

  function automatic ent_t calc(input opcode_t op,
                                input int a, input int b);
    ent_t   e;
    longint la = a;
    longint lb = b;
    e.opc = op;
    e.a   = a;
    e.b   = b;
    e.r   = 0;
    e.z   = 1'b0;
    case (op)
      PASSA: e.r = la;
      PASSB: e.r = lb;
      ADD:   e.r = la + lb;
      SUB:   e.r = la - lb;
      MULT:  e.r = la * lb;
      DIV, MOD: begin
        if (!DIV_EN || lb == 0) e.z = 1'b1;
        if (DIV_EN) begin
          if (lb == 0) e.r = (op == DIV) ? -1 : la;
          else         e.r = (op == DIV) ? la / lb : la % lb;
        end
      end
      default: e.r = 0;
    endcase
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '{default: 0};
    exp_iw = '0;
    rdy_m  = 1'b0;
    dleft  = 0;
  endtask

  task automatic model_edge();
    if (!reset_n) return;
    exp_iw = pack(m[read_pointer]);
    if (dleft > 0) begin
      dleft--;
      if (dleft == 0) m[cap_wp] = cap;
    end else if (load_en && rdy_m) begin
      if (DIV_EN && (opcode == DIV || opcode == MOD)) begin
        cap    = calc(opcode, operand_a, operand_b);
        cap_wp = write_pointer;
        dleft  = W;
      end else begin
        m[write_pointer] = calc(opcode, operand_a, operand_b);
      end
    end
    rdy_m = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (instruction_word !== exp_iw) begin
        fails++;
        $display("FAIL iw actual=%h required=%h",
                 instruction_word, exp_iw);
      end
      tests++;
      if (wr_ready !== (rdy_m && dleft == 0)) begin
        fails++;
        $display("FAIL wr_ready actual=%b required=%b",
                 wr_ready, (rdy_m && dleft == 0));
      end
      tests++;
      if (busy !== (dleft > 0)) begin
        fails++;
        $display("FAIL busy actual=%b required=%b",
                 busy, (dleft > 0));
      end
    end
  end

  task automatic lit(input string nm,
                     input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic rd_check(input string nm, input int addr,
                          input int opc, input int a, input int b,
                          input longint res, input int z);
    logic [3:0]   vo;
    int           va;
    int           vb;
    logic [63:0]  vr;
    read_pointer = AW'(addr);
    tick();
    vo = instruction_word[EW-1 -: 4];
    va = instruction_word[4*W -: W];
    vb = instruction_word[3*W -: W];
    vr = instruction_word[2*W:1];
    lit({nm, ".opc"}, vo, opc);
    lit({nm, ".a"}, va, a);
    lit({nm, ".b"}, vb, b);
    lit({nm, ".res"}, longint'(vr), res);
    lit({nm, ".dbz"}, instruction_word[0], z);
  endtask

  task automatic wr(input opcode_t op, input int a,
                    input int b, input int wp);
    opcode        = op;
    operand_a     = a;
    operand_b     = b;
    write_pointer = AW'(wp);
    load_en       = 1'b1;
    tick();
    load_en       = 1'b0;
  endtask

  task automatic wr_wait(input opcode_t op, input int a,
                         input int b, input int wp);
    int n;
    wr(op, a, b, wp);
    n = 0;
    while (!wr_ready && n < 100) begin
      n++;
      tick();
    end
    tests++;
    if (!wr_ready) begin
      fails++;
      $display("FAIL wait_ready actual=%b required=1", wr_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int min_i;
    min_i         = int'(32'h8000_0000);
    reset_n       = 1'b1;
    load_en       = 1'b0;
    opcode        = ZERO;
    operand_a     = '0;
    operand_b     = '0;
    write_pointer = '0;
    read_pointer  = '0;
    model_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #1 chk_en = 1'b1;
    repeat (3) tick();
    lit("rst_busy", busy, 0);
    reset_n = 1'b1;
    lit("rdy_at_release", wr_ready, 0);
    tick();
    lit("rdy_one_edge", wr_ready, 1);

    for (int i = 0; i < DEPTH; i++)
      rd_check("init", i, 0, 0, 0, 0, 0);

    read_pointer = 3;
    wr(ADD, 5, -7, 3);
    lit("same_edge_old", longint'(instruction_word[2*W:1]), 0);
    rd_check("add", 3, ADD, 5, -7, -2, 0);

    wr(SUB, 3, 10, 0);
    wr(MULT, -6, 7, 1);
    wr(PASSA, 32'h7fff_ffff, 0, 2);
    wr(PASSB, 9, -1, 12);
    wr(opcode_t'(4'hB), 1, 2, 13);
    wr(ZERO, 4, 5, 14);
    wr(MULT, min_i, min_i, 6);
    rd_check("sub", 0, SUB, 3, 10, -7, 0);
    rd_check("mult", 1, MULT, -6, 7, -42, 0);
    rd_check("passa", 2, PASSA, 32'h7fff_ffff, 0, 2147483647, 0);
    rd_check("passb", 12, PASSB, 9, -1, -1, 0);
    rd_check("unlisted", 13, 11, 1, 2, 0, 0);
    rd_check("zero", 14, ZERO, 4, 5, 0, 0);
    rd_check("mult_big", 6, MULT, min_i, min_i,
             64'h4000_0000_0000_0000, 0);

    wr(DIV, -17, 5, 4);
    n = 0;
    while (busy && n < 100) begin
      if (n == 5) begin
        opcode        = ADD;
        operand_a     = 1;
        operand_b     = 1;
        write_pointer = 7;
        load_en       = 1'b1;
      end else begin
        load_en = 1'b0;
      end
      n++;
      tick();
    end
    load_en = 1'b0;
    lit("div_busy_cycles", n, DIV_EN ? 32 : 0);
    rd_check("div", 4, DIV, -17, 5, DIV_EN ? -3 : 0, DIV_EN ? 0 : 1);
    rd_check("blocked", 7, 0, 0, 0, 0, 0);

    wr_wait(MOD, -17, 5, 5);
    rd_check("mod", 5, MOD, -17, 5, DIV_EN ? -2 : 0, DIV_EN ? 0 : 1);
    wr_wait(DIV, 9, 0, 8);
    rd_check("div0", 8, DIV, 9, 0, DIV_EN ? -1 : 0, 1);
    wr_wait(MOD, 9, 0, 9);
    rd_check("mod0", 9, MOD, 9, 0, DIV_EN ? 9 : 0, 1);
    wr_wait(DIV, min_i, -1, 10);
    rd_check("div_ovf", 10, DIV, min_i, -1,
             DIV_EN ? 64'sd2147483648 : 0, DIV_EN ? 0 : 1);

    wr(DIV, 100, 7, 11);
    repeat (9) tick();
    reset_n = 1'b0;
    model_reset();
    lit("abort_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    rd_check("abort_entry", 11, 0, 0, 0, 0, 0);
    rd_check("abort_clr", 4, 0, 0, 0, 0, 0);
    wr(ADD, -100, 30, 15);
    rd_check("post_rst", 15, ADD, -100, 30, -70, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
